// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings for the shift/rotate/load command sequencer.
package shift_seq_ctrl_pkg;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_SHR  = 3'b011;
   localparam logic [2:0] OP_ROTL = 3'b100;
   localparam logic [2:0] OP_ROTR = 3'b101;

   localparam logic [1:0] MODE_SHIFT = 2'b00;
   localparam logic [1:0] MODE_ROT   = 2'b01;
   localparam logic [1:0] MODE_LOAD  = 2'b10;
   localparam logic [1:0] MODE_HOLD  = 2'b11;

   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/shift_seq_ctrl_dec.sv
// Combinational op decoder: register mode/direction plus command classification.
module shift_seq_dec
   import shift_seq_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic [2:0]       op_i,
   input  logic [CNT_W-1:0] cnt_i,
   output logic [1:0]       mode_o,
   output logic             dir_o,
   output logic             uses_sin_o,
   output logic             zero_len_o,
   output logic             illegal_o
);

   // Decode op into control fields; unknown codes are illegal.
   always_comb begin
      mode_o     = MODE_HOLD;
      dir_o      = DIR_L;
      uses_sin_o = 1'b0;
      zero_len_o = 1'b0;
      illegal_o  = 1'b0;
      case (op_i)
         OP_NOP:  zero_len_o = 1'b1;
         OP_LOAD: mode_o = MODE_LOAD;
         OP_SHL: begin
            mode_o     = MODE_SHIFT;
            uses_sin_o = 1'b1;
            zero_len_o = (cnt_i == '0);
         end
         OP_SHR: begin
            mode_o     = MODE_SHIFT;
            dir_o      = DIR_R;
            uses_sin_o = 1'b1;
            zero_len_o = (cnt_i == '0);
         end
         OP_ROTL: begin
            mode_o     = MODE_ROT;
            zero_len_o = (cnt_i == '0);
         end
         OP_ROTR: begin
            mode_o     = MODE_ROT;
            dir_o      = DIR_R;
            zero_len_o = (cnt_i == '0);
         end
         default: illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for the 4-bit shift/rotate/load register.
// Optional SHIFT_SEQ_CTRL_QUEUE_EN adds a one-entry command holding register.
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [3:0]       cmd_data,
   input  logic             sin_data,
   output logic             sin_req,
   output logic             reg_enb,
   output logic             reg_dir,
   output logic [1:0]       reg_mode,
   output logic [3:0]       reg_d,
   output logic             reg_sin,
   output logic             busy,
   output logic             done,
   output logic             cmd_err
);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sin_q, sin_d;
   logic             enb_q, enb_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic [3:0]       d_q, d_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic             accept;
   logic             launch;
   logic [2:0]       l_op;
   logic [CNT_W-1:0] l_cnt;
   logic [3:0]       l_data;
   logic [1:0]       dec_mode;
   logic             dec_dir, dec_uses_sin, dec_zero_len, dec_illegal;
   logic             run_sin;

`ifdef SHIFT_SEQ_CTRL_QUEUE_EN
   logic             q_full_q, q_full_d;
   logic [2:0]       q_op_q, q_op_d;
   logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
   logic [3:0]       q_data_q, q_data_d;

   // A queued command always has priority over the live input when launching.
   assign cmd_ready = !q_full_q;
   assign l_op      = q_full_q ? q_op_q   : cmd_op;
   assign l_cnt     = q_full_q ? q_cnt_q  : cmd_cnt;
   assign l_data    = q_full_q ? q_data_q : cmd_data;
`else
   assign cmd_ready = (state_q == ST_IDLE);
   assign l_op      = cmd_op;
   assign l_cnt     = cmd_cnt;
   assign l_data    = cmd_data;
`endif

   assign accept = cmd_valid && cmd_ready;

   shift_seq_dec #(.CNT_W(CNT_W)) u_dec (
      .op_i       (l_op),
      .cnt_i      (l_cnt),
      .mode_o     (dec_mode),
      .dir_o      (dec_dir),
      .uses_sin_o (dec_uses_sin),
      .zero_len_o (dec_zero_len),
      .illegal_o  (dec_illegal)
   );

   // Serial bits are consumed only while a shift op is running.
   assign run_sin = (state_q == ST_RUN) && sin_q;
   assign sin_req = run_sin;
   assign reg_sin = run_sin & sin_data;

   assign reg_enb  = enb_q;
   assign reg_dir  = dir_q;
   assign reg_mode = mode_q;
   assign reg_d    = d_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cmd_err  = err_q;

   // Next-state and registered-output computation.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sin_d   = sin_q;
      dir_d   = dir_q;
      mode_d  = MODE_HOLD;
      d_d     = d_q;
      err_d   = err_q;
      launch  = 1'b0;
`ifdef SHIFT_SEQ_CTRL_QUEUE_EN
      q_full_d = q_full_q;
      q_op_d   = q_op_q;
      q_cnt_d  = q_cnt_q;
      q_data_d = q_data_q;
`endif
      case (state_q)
         ST_IDLE: launch = accept;
         ST_RUN: begin
            cnt_d = CNT_W'(cnt_q - CNT_W'(1));
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_FIN;
            end else begin
               mode_d = mode_q;
            end
`ifdef SHIFT_SEQ_CTRL_QUEUE_EN
            if (accept) begin
               q_full_d = 1'b1;
               q_op_d   = cmd_op;
               q_cnt_d  = cmd_cnt;
               q_data_d = cmd_data;
            end
`endif
         end
         ST_FIN: begin
            state_d = ST_IDLE;
`ifdef SHIFT_SEQ_CTRL_QUEUE_EN
            if (q_full_q) begin
               launch   = 1'b1;
               q_full_d = 1'b0;
            end else begin
               launch = accept;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
         if (dec_illegal) begin
            err_d = 1'b1;
         end
         if (dec_illegal || dec_zero_len) begin
            state_d = ST_FIN;
         end else begin
            state_d = ST_RUN;
            cnt_d   = (l_op == OP_LOAD) ? CNT_W'(1) : l_cnt;
            mode_d  = dec_mode;
            dir_d   = dec_dir;
            sin_d   = dec_uses_sin;
            if (l_op == OP_LOAD) begin
               d_d = l_data;
            end
         end
      end

      enb_d  = (state_d == ST_RUN);
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_FIN);
   end

   // State and output registers; reset aborts any command in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sin_q   <= 1'b0;
         enb_q   <= 1'b0;
         dir_q   <= DIR_L;
         mode_q  <= MODE_HOLD;
         d_q     <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sin_q   <= sin_d;
         enb_q   <= enb_d;
         dir_q   <= dir_d;
         mode_q  <= mode_d;
         d_q     <= d_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef SHIFT_SEQ_CTRL_QUEUE_EN
   // One-entry command holding register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_full_q <= 1'b0;
         q_op_q   <= OP_NOP;
         q_cnt_q  <= '0;
         q_data_q <= 4'd0;
      end else begin
         q_full_q <= q_full_d;
         q_op_q   <= q_op_d;
         q_cnt_q  <= q_cnt_d;
         q_data_q <= q_data_d;
      end
   end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl.
module tb_shift_seq_ctrl;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_op;
   logic [CNT_W-1:0] cmd_cnt;
   logic [3:0]       cmd_data;
   logic             sin_data;
   logic             sin_req;
   logic             reg_enb;
   logic             reg_dir;
   logic [1:0]       reg_mode;
   logic [3:0]       reg_d;
   logic             reg_sin;
   logic             busy;
   logic             done;
   logic             cmd_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_cnt   (cmd_cnt),
      .cmd_data  (cmd_data),
      .sin_data  (sin_data),
      .sin_req   (sin_req),
      .reg_enb   (reg_enb),
      .reg_dir   (reg_dir),
      .reg_mode  (reg_mode),
      .reg_d     (reg_d),
      .reg_sin   (reg_sin),
      .busy      (busy),
      .done      (done),
      .cmd_err   (cmd_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one command in an idle cycle; returns in the cycle after acceptance.
   task automatic issue(input logic [2:0] op, input logic [CNT_W-1:0] cnt, input logic [3:0] data);
      cmd_op    = op;
      cmd_cnt   = cnt;
      cmd_data  = data;
      cmd_valid = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL issue_ready op=%b got=%b exp=1", op, cmd_ready);
      end
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_op = 3'b000; cmd_cnt = '0; cmd_data = 4'd0; sin_data = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
      checks++;
      if ({cmd_ready, reg_mode, reg_enb, done, cmd_err, busy, reg_d} !== {1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0}) begin
         errors++;
         $display("FAIL reset got=%b exp=%b", {cmd_ready, reg_mode, reg_enb, done, cmd_err, busy, reg_d},
                  {1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
      end
   endtask

   task automatic test_load();
      issue(3'b001, 4'd0, 4'b1011);
      checks++;
      if ({reg_enb, reg_mode, reg_d, busy, done} !== {1'b1, 2'b10, 4'b1011, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL load_run got=%b exp=%b", {reg_enb, reg_mode, reg_d, busy, done}, {1'b1, 2'b10, 4'b1011, 1'b1, 1'b0});
      end
      step();
      checks++;
      if ({reg_enb, reg_mode, busy, done} !== {1'b0, 2'b11, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL load_done got=%b exp=%b", {reg_enb, reg_mode, busy, done}, {1'b0, 2'b11, 1'b0, 1'b1});
      end
      step();
      checks++;
      if ({cmd_ready, done, reg_d} !== {1'b1, 1'b0, 4'b1011}) begin
         errors++;
         $display("FAIL load_idle got=%b exp=%b", {cmd_ready, done, reg_d}, {1'b1, 1'b0, 4'b1011});
      end
   endtask

   task automatic test_shr();
      logic [2:0] bits;
      bits = 3'b101;
      issue(3'b011, 4'd3, 4'd0);
      for (int i = 0; i < 3; i++) begin
         sin_data = bits[2-i];
         #1;
         checks++;
         if ({reg_enb, reg_dir, reg_mode, sin_req, reg_sin, busy} !== {1'b1, 1'b1, 2'b00, 1'b1, bits[2-i], 1'b1}) begin
            errors++;
            $display("FAIL shr_run%0d got=%b exp=%b", i, {reg_enb, reg_dir, reg_mode, sin_req, reg_sin, busy},
                     {1'b1, 1'b1, 2'b00, 1'b1, bits[2-i], 1'b1});
         end
         step();
      end
      sin_data = 1'b1;
      #1;
      checks++;
      if ({reg_enb, reg_mode, sin_req, reg_sin, done, reg_d} !== {1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 4'b1011}) begin
         errors++;
         $display("FAIL shr_done got=%b exp=%b", {reg_enb, reg_mode, sin_req, reg_sin, done, reg_d},
                  {1'b0, 2'b11, 1'b0, 1'b0, 1'b1, 4'b1011});
      end
      step();
   endtask

   task automatic test_rotl_zero();
      sin_data = 1'b1;
      issue(3'b100, 4'd5, 4'd0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({reg_enb, reg_dir, reg_mode, sin_req, reg_sin, done} !== {1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rotl_run%0d got=%b exp=%b", i, {reg_enb, reg_dir, reg_mode, sin_req, reg_sin, done},
                     {1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0});
         end
         step();
      end
      checks++;
      if ({reg_enb, reg_mode, done} !== {1'b0, 2'b11, 1'b1}) begin
         errors++;
         $display("FAIL rotl_done got=%b exp=%b", {reg_enb, reg_mode, done}, {1'b0, 2'b11, 1'b1});
      end
      step();
      issue(3'b010, 4'd0, 4'd0);
      checks++;
      if ({reg_enb, reg_mode, busy, done, sin_req} !== {1'b0, 2'b11, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL zero_len got=%b exp=%b", {reg_enb, reg_mode, busy, done, sin_req}, {1'b0, 2'b11, 1'b0, 1'b1, 1'b0});
      end
      step();
   endtask

   task automatic test_illegal();
      issue(3'b110, 4'd3, 4'd0);
      checks++;
      if ({cmd_err, done, reg_enb, busy} !== {1'b1, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL illegal got=%b exp=%b", {cmd_err, done, reg_enb, busy}, {1'b1, 1'b1, 1'b0, 1'b0});
      end
      step(); step();
      checks++;
      if ({cmd_err, done} !== {1'b1, 1'b0}) begin
         errors++;
         $display("FAIL err_sticky got=%b exp=%b", {cmd_err, done}, {1'b1, 1'b0});
      end
   endtask

   // ROTR cnt=2 followed by a LOAD presented during RUN.
   task automatic test_back_to_back();
      logic [11:0] modes;
      logic [5:0]  dones;
      logic [11:0] exp_modes;
      logic [5:0]  exp_dones;
      logic        acc;
`ifdef SHIFT_SEQ_CTRL_QUEUE_EN
      exp_modes = {2'b01, 2'b01, 2'b11, 2'b10, 2'b11, 2'b11};
      exp_dones = 6'b001010;
`else
      exp_modes = {2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b11};
      exp_dones = 6'b001001;
`endif
      modes = '0;
      dones = '0;
      issue(3'b101, 4'd2, 4'd0);
      cmd_op = 3'b001; cmd_data = 4'b0110; cmd_cnt = 4'd0; cmd_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         modes = {modes[9:0], reg_mode};
         dones = {dones[4:0], done};
         acc = cmd_valid && cmd_ready;
         step();
         if (acc) cmd_valid = 1'b0;
      end
      checks++;
      if (modes !== exp_modes) begin
         errors++;
         $display("FAIL b2b_modes got=%b exp=%b", modes, exp_modes);
      end
      checks++;
      if (dones !== exp_dones) begin
         errors++;
         $display("FAIL b2b_dones got=%b exp=%b", dones, exp_dones);
      end
      checks++;
      if ({reg_d, cmd_valid, cmd_ready} !== {4'b0110, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_end got=%b exp=%b", {reg_d, cmd_valid, cmd_ready}, {4'b0110, 1'b0, 1'b1});
      end
   endtask

   task automatic test_reset_abort();
      int done_seen;
      issue(3'b010, 4'd7, 4'd0);
      step(); step();
      checks++;
      if ({reg_enb, busy} !== 2'b11) begin
         errors++;
         $display("FAIL abort_pre got=%b exp=11", {reg_enb, busy});
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({reg_enb, reg_mode, busy, done, cmd_err, sin_req, cmd_ready} !== {1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL abort_rst got=%b exp=%b", {reg_enb, reg_mode, busy, done, cmd_err, sin_req, cmd_ready},
                  {1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      end
      step();
      reset = 1'b0;
      done_seen = 0;
      for (int c = 0; c < 10; c++) begin
         if (done === 1'b1 || reg_enb === 1'b1) done_seen++;
         step();
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL abort_nodone got=%0d exp=0", done_seen);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shr();
      test_rotl_zero();
      test_illegal();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Command sequencer for the 4-bit shift/rotate/load register in the same design.
- Accepts one command per valid/ready handshake: load, shift left/right by N, or rotate left/right by N.
- Expands each command into the per-cycle control word for the register: enable, direction, mode, parallel data and serial-in bit.
- Pulls serial-in bits from an upstream bit source and reports completion to the host.

Parameters:
CNT_W, 4, width of the shift/rotate repeat count; max count 2**CNT_W-1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  controller can accept a command
cmd_op  input  3  000 NOP, 001 LOAD, 010 SHL, 011 SHR, 100 ROTL, 101 ROTR, 11x illegal
cmd_cnt  input  CNT_W  repeat count for shift/rotate ops
cmd_data  input  4  parallel data for LOAD
sin_data  input  1  serial bit from upstream source
sin_req  output  1  sin_data consumed this cycle
reg_enb  output  1  register enable
reg_dir  output  1  0 left, 1 right
reg_mode  output  2  00 shift, 01 rotate, 10 load, 11 hold
reg_d  output  4  register parallel data
reg_sin  output  1  register serial input
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
cmd_err  output  1  sticky illegal-op flag

Behaviour:
- Reset (asynchronous, active-high) forces state IDLE and clears all registered outputs:
  - reg_enb=0, reg_dir=0, reg_mode=11, reg_d=0, busy=0, done=0, cmd_err=0, counter=0.
  - In IDLE after reset, cmd_ready=1.
- Reset asserted mid-command aborts it immediately; no done pulse is produced.
- States: IDLE, RUN, FIN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture op, cnt and data.
  - NOP, or SHL/SHR/ROTL/ROTR with cnt==0: go to FIN, no reg_enb pulse.
  - Illegal op: set cmd_err, go to FIN.
  - Otherwise: go to RUN with counter = cnt (LOAD uses 1).
- RUN:
  - cmd_ready=0, busy=1.
  - reg_enb=1 every cycle; reg_mode and reg_dir decoded from the captured op.
  - Counter decrements each cycle; on counter==1, go to FIN.
  - Exactly cnt consecutive reg_enb cycles, no gaps.
- FIN:
  - done=1 for exactly one cycle, busy=0, reg_enb=0, reg_mode=11.
  - Then go to IDLE; cmd_ready returns the following cycle.
- Control outputs (reg_enb, reg_dir, reg_mode, reg_d, busy, done) are registered.
  - First reg_enb occurs the cycle after acceptance.
  - done occurs the cycle after the last reg_enb.
- reg_d holds the captured cmd_data from acceptance until the next LOAD.
- reg_sin and sin_req are combinational:
  - reg_sin = sin_data while RUN with a SHL/SHR op, else 0.
  - sin_req = 1 in the same cycles.
  - ROT and LOAD never assert sin_req.
- cmd_err is sticky until reset.
- When no command is in progress: reg_enb=0 and reg_mode=11 (hold).

Optional Feature:
- Macro: SHIFT_SEQ_CTRL_QUEUE_EN.
- Defined:
  - Adds a one-entry command holding register.
  - cmd_ready = !queue_full, so one command can be accepted while RUN/FIN.
  - On leaving FIN, a queued command is issued directly into RUN, or into FIN for zero-length/NOP/illegal ops.
  - One idle (hold) cycle occurs between back-to-back commands.
  - done still pulses once per command.
- Undefined: cmd_ready is high only in IDLE, per the state description above.

Decomposition:
- Shared package holds:
  - op codes: OP_NOP, OP_LOAD, OP_SHL, OP_SHR, OP_ROTL, OP_ROTR
  - mode codes: MODE_SHIFT=00, MODE_ROT=01, MODE_LOAD=10, MODE_HOLD=11
  - direction codes: DIR_L=0, DIR_R=1
  - state encodings
- One sub-module, shift_seq_dec: combinational op decoder producing mode, dir, uses_sin, zero_len and illegal.

Test Plan:
1. Reset: hold reset high, then release → cmd_ready=1, reg_mode=11, reg_enb=0, done=0, cmd_err=0.
2. LOAD: op=001, data=1011 accepted at cycle T → T+1: reg_enb=1, reg_mode=10, reg_d=1011; T+2: done=1, reg_enb=0; T+3: cmd_ready=1.
3. SHR: op=011, cnt=3, sin_data sequence 1,0,1 → reg_enb=1, reg_dir=1, reg_mode=00 for 3 consecutive cycles; sin_req=1 in those cycles; reg_sin=1,0,1; done on the 4th cycle after acceptance.
4. ROTL: op=100, cnt=5 → 5 enable cycles with reg_mode=01, reg_dir=0, sin_req=0; shift with cnt=0 → done at T+1 with no reg_enb.
5. Illegal op 110 → cmd_err=1 (sticky), done at T+1, no reg_enb; reset during a SHL cnt=7 at its 3rd enable cycle → all outputs at reset values, no done.
6. With SHIFT_SEQ_CTRL_QUEUE_EN: ROTR cnt=2, then LOAD presented during RUN → second command accepted while busy; two done pulses; exactly one hold cycle between the last ROTR enable and the LOAD enable.
